// File: rtl/exp_fp32_stream_ctrl_if.sv
// AXI4-Stream style channel carrying one fp32 word plus a frame marker.
// The master drives payload and valid; the slave drives ready.
interface exp_fp32_stream_ctrl_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/exp_fp32_stream_ctrl.sv
// Wraps a fixed-latency, non-stallable exp() core with AXI4-Stream handshakes.
// Operands are admitted only when the result FIFO has guaranteed room for them.
module exp_fp32_stream_ctrl #(
  parameter int LATENCY    = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  exp_fp32_stream_ctrl_if.slave  s_axis,
  exp_fp32_stream_ctrl_if.master m_axis,
  output logic        core_aclken,
  output logic [31:0] core_a_tdata,
  output logic        core_a_tvalid,
  input  logic [31:0] core_result_tdata,
  input  logic        core_result_tvalid,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_unexpected
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic             ready_en;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [32:0]      mem [FIFO_DEPTH];
  logic [CNT_W:0]   occupied;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             unexpected;
  logic             tlast_core;

  // Every FIFO slot is either holding a result or reserved for one still in the core.
  assign occupied      = {1'b0, fifo_count} + {1'b0, inflight};
  assign s_axis.tready = ready_en && (occupied < DEPTH_EXT);
  assign accept        = s_axis.tvalid && s_axis.tready;

  assign core_a_tvalid = accept;
  assign core_a_tdata  = s_axis.tdata;
  assign core_aclken   = accept || (inflight != '0);

  assign full       = (fifo_count == DEPTH_CNT);
  assign push       = core_result_tvalid && !full;
  assign pop        = m_axis.tvalid && m_axis.tready;
  // With LATENCY=0 a matched result coincides with its own accept.
  assign unexpected = core_result_tvalid && (inflight == '0) && !accept;

  assign m_axis.tvalid = (fifo_count != '0);
  assign m_axis.tdata  = mem[rd_ptr][31:0];
  assign m_axis.tlast  = mem[rd_ptr][32];

  assign busy = (inflight != '0) || (fifo_count != '0);

  generate
    if (LATENCY == 0) begin : g_tlast_comb
      assign tlast_core = s_axis.tlast;
    end else begin : g_tlast_pipe
      logic [LATENCY-1:0] tlast_sr;

      always_ff @(posedge aclk) begin
        if (!aresetn) begin
          tlast_sr <= '0;
        end else if (core_aclken) begin
          tlast_sr[0] <= accept && s_axis.tlast;
          for (int i = 1; i < LATENCY; i++) begin
            tlast_sr[i] <= tlast_sr[i-1];
          end
        end
      end

      assign tlast_core = tlast_sr[LATENCY-1];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ready_en       <= 1'b0;
      inflight       <= '0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case ({accept, core_result_tvalid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      err_overflow   <= err_overflow || (core_result_tvalid && full);
      err_unexpected <= err_unexpected || unexpected;
    end
  end

  // Storage needs no reset; validity is tracked by fifo_count alone.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {tlast_core, core_result_tdata};
  end

endmodule
